// File: rtl/pio_irq_port.sv
// Avalon-MM parallel I/O port: per-bit direction, atomic set/clear, synchronised inputs,
// edge capture and a maskable level interrupt. Optional input debounce via PIO_DEBOUNCE_EN.
module pio_irq_port #(
  parameter int unsigned WIDTH           = 16,
  parameter logic [31:0] RESET_OUT       = 32'h0,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  input  logic [WIDTH-1:0] pio_in,
  output logic [WIDTH-1:0] pio_out,
  output logic [WIDTH-1:0] pio_oe,
  output logic             irq
);

  typedef enum logic [2:0] {
    AddrData = 3'd0,
    AddrDir  = 3'd1,
    AddrMask = 3'd2,
    AddrCap  = 3'd3,
    AddrRise = 3'd4,
    AddrFall = 3'd5,
    AddrSet  = 3'd6,
    AddrClr  = 3'd7
  } reg_addr_e;

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("pio_irq_port: WIDTH must be in 1..32");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("pio_irq_port: DEBOUNCE_CYCLES must be at least 1");
  end

  reg_addr_e        addr;
  logic [WIDTH-1:0] wdata;

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] cap_clr;

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] in_s;
  logic [WIDTH-1:0] hist_q;
  logic [1:0]       prime_q, prime_d;
  logic             primed;
  logic [WIDTH-1:0] rise_hit, fall_hit;

  logic             irq_q, irq_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [WIDTH-1:0] rd_mux;

  assign addr  = reg_addr_e'(avs_address);
  assign wdata = avs_writedata[WIDTH-1:0];

  if (WIDTH < 32) begin : g_wd_unused
    logic unused_wdata;
    assign unused_wdata = ^avs_writedata[31:WIDTH];
  end

  // Input path: 2-flop synchroniser, optionally followed by a per-bit debouncer.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pio_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef PIO_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [WIDTH-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]           deb_q, deb_d;

  // A bit's counter runs only while the synchronised value disagrees with the accepted one.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (int'(cnt_q[i]) + 1 >= int'(DEBOUNCE_CYCLES)) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      deb_q <= '0;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign in_s = deb_q;
`else
  assign in_s = sync2_q;
`endif

  // Edges stay suppressed until the synchroniser has refilled after reset, so pins that are
  // already high when reset releases do not look like rising edges.
  assign primed  = (prime_q == 2'd3);
  assign prime_d = primed ? prime_q : prime_q + 2'd1;

  assign rise_hit = primed ? (in_s & ~hist_q & rise_q & ~dir_q) : '0;
  assign fall_hit = primed ? (~in_s & hist_q & fall_q & ~dir_q) : '0;

  always_comb begin
    out_d   = out_q;
    dir_d   = dir_q;
    mask_d  = mask_q;
    rise_d  = rise_q;
    fall_d  = fall_q;
    cap_clr = '0;
    if (avs_write) begin
      unique case (addr)
        AddrData: out_d   = wdata;
        AddrDir:  dir_d   = wdata;
        AddrMask: mask_d  = wdata;
        AddrCap:  cap_clr = wdata;
        AddrRise: rise_d  = wdata;
        AddrFall: fall_d  = wdata;
        AddrSet:  out_d   = out_q | wdata;
        AddrClr:  out_d   = out_q & ~wdata;
        default:  ;
      endcase
    end
  end

  // A new edge overrides a same-cycle clear on that bit.
  assign cap_d = (cap_q & ~cap_clr) | rise_hit | fall_hit;
  assign irq_d = |(cap_q & mask_q);

  always_comb begin
    rd_mux = '0;
    unique case (addr)
      AddrData: rd_mux = (dir_q & out_q) | (~dir_q & in_s);
      AddrDir:  rd_mux = dir_q;
      AddrMask: rd_mux = mask_q;
      AddrCap:  rd_mux = cap_q;
      AddrRise: rd_mux = rise_q;
      AddrFall: rd_mux = fall_q;
      AddrSet:  rd_mux = '0;
      AddrClr:  rd_mux = '0;
      default:  rd_mux = '0;
    endcase
  end

  assign rdata_d = avs_read ? 32'(rd_mux) : rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q   <= RESET_OUT[WIDTH-1:0];
      dir_q   <= '0;
      mask_q  <= '0;
      cap_q   <= '0;
      rise_q  <= '1;
      fall_q  <= '0;
      hist_q  <= '0;
      prime_q <= 2'd0;
      irq_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      out_q   <= out_d;
      dir_q   <= dir_d;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      hist_q  <= in_s;
      prime_q <= prime_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
    end
  end

  assign pio_out      = out_q;
  assign pio_oe       = dir_q;
  assign irq          = irq_q;
  assign avs_readdata = rdata_q;

endmodule

// File: tb/tb_pio_irq_port.sv
// Scoreboard bench for pio_irq_port: reads push expected data, a monitor pops and compares.
module tb_pio_irq_port;

  localparam int unsigned W = 16;
`ifdef PIO_DEBOUNCE_EN
  localparam int Lat = 6;
  localparam logic [15:0] HeldPin = 16'h0000;
`else
  localparam int Lat = 2;
  localparam logic [15:0] HeldPin = 16'hFFFF;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    avs_address;
  logic          avs_read;
  logic          avs_write;
  logic [31:0]   avs_writedata;
  logic [31:0]   avs_readdata;
  logic [W-1:0]  pio_in;
  logic [W-1:0]  pio_out;
  logic [W-1:0]  pio_oe;
  logic          irq;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  logic rd_seen = 1'b0;

  pio_irq_port #(
    .WIDTH          (W),
    .RESET_OUT      (32'h0000_00A5),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata (avs_readdata),
    .pio_in       (pio_in),
    .pio_out      (pio_out),
    .pio_oe       (pio_oe),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  // Monitor: a read accepted at a clock edge presents its data until the next read.
  always @(posedge clk) rd_seen <= avs_read && !reset;

  always @(negedge clk) begin
    exp_t e;
    if (rd_seen) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_read: got %h, nothing expected", avs_readdata);
      end else begin
        e = exp_q.pop_front();
        if (avs_readdata !== e.data) begin
          n_err++;
          $display("FAIL %s: got %h, want %h", e.name, avs_readdata, e.data);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    idle(1);
    avs_write     = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
    avs_address = a;
    avs_read    = 1'b1;
    exp_q.push_back('{nm, e});
    idle(1);
    avs_read    = 1'b0;
  endtask

  task automatic rdwr(input logic [2:0] a, input logic [31:0] d, input logic [31:0] e,
                      input string nm);
    avs_address   = a;
    avs_writedata = d;
    avs_read      = 1'b1;
    avs_write     = 1'b1;
    exp_q.push_back('{nm, e});
    idle(1);
    avs_read      = 1'b0;
    avs_write     = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, want);
    end
  endtask

  initial begin
    reset         = 1'b1;
    avs_address   = '0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;
    pio_in        = '0;
    idle(3);
    reset = 1'b0;

    // Reset state
    chk("rst_out", 32'(pio_out), 32'h00A5);
    chk("rst_oe", 32'(pio_oe), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_rdata", avs_readdata, 32'h0);
    idle(4);
    rd(3'd4, 32'hFFFF, "rst_rise");
    rd(3'd0, 32'h0000, "rst_data");
    rd(3'd3, 32'h0000, "rst_cap");

    // Pins rising on inputs are captured; mask keeps irq low
    pio_in = 16'h5A3C;
    idle(Lat + 2);
    rd(3'd0, 32'h5A3C, "data_pin");
    rd(3'd3, 32'h5A3C, "cap_rise");
    chk("irq_masked", 32'(irq), 32'h0);
    wr(3'd3, 32'hFFFF);
    rd(3'd3, 32'h0000, "cap_w1c");

    // Direction, OUT, SET, CLR
    wr(3'd5, 32'hFFFF);
    wr(3'd1, 32'h00FF);
    wr(3'd0, 32'h1234);
    wr(3'd6, 32'h0300);
    wr(3'd7, 32'h0004);
    chk("out_setclr", 32'(pio_out), 32'h1330);
    chk("oe_dir", 32'(pio_oe), 32'h00FF);
    rd(3'd1, 32'h00FF, "dir_rd");
    rd(3'd6, 32'h0000, "set_rd0");
    rd(3'd7, 32'h0000, "clr_rd0");

    // Mixed DATA read; output bits must not capture edges
    pio_in = 16'hAB00;
    idle(Lat + 2);
    rd(3'd0, 32'hAB30, "data_mix");
    rd(3'd3, 32'hF100, "cap_dir_masked");
    wr(3'd5, 32'h0000);
    wr(3'd3, 32'hFFFF);

    // Simultaneous read/write returns the old value
    rdwr(3'd2, 32'h0008, 32'h0000, "mask_rw_old");
    rd(3'd2, 32'h0008, "mask_new");
    wr(3'd1, 32'h0000);
    rd(3'd0, 32'hAB00, "data_all_in");
    rd(3'd3, 32'h0000, "cap_clear");

    // bit3 rise: CAP timing, irq one cycle later, clear drops irq one cycle after
    pio_in = 16'hAB08;
    idle(Lat);
    rd(3'd3, 32'h0000, "cap_pre_edge");
    chk("irq_pre", 32'(irq), 32'h0);
    rd(3'd3, 32'h0008, "cap_bit3");
    chk("irq_set", 32'(irq), 32'h1);
    wr(3'd3, 32'h0008);
    chk("irq_hold", 32'(irq), 32'h1);
    idle(1);
    chk("irq_clr", 32'(irq), 32'h0);

    // Falling edges only; clear colliding with a new fall loses
    wr(3'd4, 32'h0000);
    wr(3'd5, 32'h0001);
    wr(3'd2, 32'h0001);
    pio_in = 16'hAB09;
    idle(Lat + 2);
    rd(3'd3, 32'h0000, "cap_no_rise");
    pio_in = 16'hAB08;
    idle(Lat + 2);
    chk("irq_fall", 32'(irq), 32'h1);
    rd(3'd3, 32'h0001, "cap_fall");
    pio_in = 16'hAB09;
    idle(Lat + 2);
    pio_in = 16'hAB08;
    idle(Lat);
    wr(3'd3, 32'h0001);
    rd(3'd3, 32'h0001, "cap_edge_wins");
    chk("irq_stays", 32'(irq), 32'h1);
    idle(2);
    chk("irq_stays2", 32'(irq), 32'h1);
    wr(3'd3, 32'hFFFF);
    idle(1);
    chk("irq_final_clr", 32'(irq), 32'h0);
    rd(3'd5, 32'h0001, "fall_rd");

    // Reset with a read in flight, pins held through reset release
    pio_in      = HeldPin;
    avs_address = 3'd4;
    avs_read    = 1'b1;
    reset       = 1'b1;
    idle(1);
    avs_read = 1'b0;
    chk("rst_inflight", avs_readdata, 32'h0);
    idle(2);
    chk("rst2_out", 32'(pio_out), 32'h00A5);
    chk("rst2_oe", 32'(pio_oe), 32'h0);
    reset = 1'b0;
    wr(3'd2, 32'hFFFF);
    for (int i = 0; i < 10; i++) begin
      idle(1);
      chk("irq_no_spurious", 32'(irq), 32'h0);
    end
    rd(3'd3, 32'h0000, "cap_no_spurious");
    rd(3'd0, 32'(HeldPin), "data_held");

`ifdef PIO_DEBOUNCE_EN
    // Short pulse is rejected, long level is accepted
    pio_in = 16'h0001;
    idle(3);
    pio_in = 16'h0000;
    idle(10);
    rd(3'd0, 32'h0000, "deb_pulse_data");
    rd(3'd3, 32'h0000, "deb_pulse_cap");
    chk("deb_pulse_irq", 32'(irq), 32'h0);
    pio_in = 16'h0001;
    idle(6);
    rd(3'd0, 32'h0001, "deb_hold_data");
    rd(3'd3, 32'h0001, "deb_hold_cap");
    chk("deb_hold_irq", 32'(irq), 32'h1);
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d reads outstanding, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
